// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master pipelined Wishbone arbiter with ack timeout
module wb_bus_arbiter #(
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255,
    parameter int OUT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_wb_cyc,
    input  logic        m0_wb_stb,
    input  logic        m0_wb_we,
    input  logic [31:0] m0_wb_addr,
    input  logic [31:0] m0_wb_wdata,
    output logic        m0_wb_ack,
    output logic        m0_wb_err,
    output logic        m0_wb_stall,
    output logic [31:0] m0_wb_rdata,
    input  logic        m1_wb_cyc,
    input  logic        m1_wb_stb,
    input  logic        m1_wb_we,
    input  logic [31:0] m1_wb_addr,
    input  logic [31:0] m1_wb_wdata,
    output logic        m1_wb_ack,
    output logic        m1_wb_err,
    output logic        m1_wb_stall,
    output logic [31:0] m1_wb_rdata,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [OUT_W-1:0] OUT_MAX = '1;
    localparam logic [15:0]      TMO     = 16'(TIMEOUT);

    state_t           state;
    logic             last_grant;
    logic [OUT_W-1:0] outstanding;
    logic [15:0]      timer;

    logic        own0, own1, owned, timeout_hit;
    logic        sel_cyc, sel_stb, sel_we;
    logic [31:0] sel_addr, sel_data;
    logic        accept, done;

    assign own0        = (state == OWN0);
    assign own1        = (state == OWN1);
    assign owned       = own0 | own1;
    // The timeout cycle itself is the error pulse: the bus is cut and the owner sees err.
    assign timeout_hit = owned && (timer == TMO);

    assign sel_cyc  = own1 ? m1_wb_cyc   : m0_wb_cyc;
    assign sel_stb  = own1 ? m1_wb_stb   : m0_wb_stb;
    assign sel_we   = own1 ? m1_wb_we    : m0_wb_we;
    assign sel_addr = own1 ? m1_wb_addr  : m0_wb_addr;
    assign sel_data = own1 ? m1_wb_wdata : m0_wb_wdata;

    assign o_wb_cyc  = owned & ~timeout_hit & sel_cyc;
    assign o_wb_stb  = owned & ~timeout_hit & sel_stb;
    assign o_wb_we   = owned & sel_we;
    assign o_wb_addr = owned ? sel_addr : 32'd0;
    assign o_wb_data = owned ? sel_data : 32'd0;

    assign m0_wb_stall = (own0 & ~timeout_hit) ? i_wb_stall : 1'b1;
    assign m1_wb_stall = (own1 & ~timeout_hit) ? i_wb_stall : 1'b1;
    assign m0_wb_ack   = own0 & ~timeout_hit & i_wb_ack;
    assign m1_wb_ack   = own1 & ~timeout_hit & i_wb_ack;
    assign m0_wb_err   = own0 & (timeout_hit | i_wb_err);
    assign m1_wb_err   = own1 & (timeout_hit | i_wb_err);
    assign m0_wb_rdata = i_wb_data;
    assign m1_wb_rdata = i_wb_data;

    assign accept  = o_wb_stb & ~i_wb_stall;
    assign done    = i_wb_ack | i_wb_err;
    assign o_grant = {own1, own0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            outstanding <= '0;
            timer       <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    timer       <= 16'd0;
                    if (m0_wb_cyc && m1_wb_cyc) begin
                        if (RR_MODE != 0 && !last_grant)
                            state <= OWN1;
                        else
                            state <= OWN0;
                    end else if (m0_wb_cyc) begin
                        state <= OWN0;
                    end else if (m1_wb_cyc) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!sel_cyc || timeout_hit) begin
                        state       <= IDLE;
                        last_grant  <= own1;
                        outstanding <= '0;
                        timer       <= 16'd0;
                    end else begin
                        if (accept && !done && outstanding != OUT_MAX)
                            outstanding <= outstanding + OUT_W'(1);
                        else if (done && !accept && outstanding != '0)
                            outstanding <= outstanding - OUT_W'(1);
                        if (accept || done || outstanding == '0)
                            timer <= 16'd0;
                        else
                            timer <= timer + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed vector bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

    logic        clk, reset;
    logic        m0_wb_cyc, m0_wb_stb, m0_wb_we, m1_wb_cyc, m1_wb_stb, m1_wb_we;
    logic [31:0] m0_wb_addr, m0_wb_wdata, m1_wb_addr, m1_wb_wdata;
    logic        m0_wb_ack, m0_wb_err, m0_wb_stall, m1_wb_ack, m1_wb_err, m1_wb_stall;
    logic [31:0] m0_wb_rdata, m1_wb_rdata;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data, i_wb_data;
    logic        i_wb_ack, i_wb_stall, i_wb_err;
    logic [1:0]  o_grant;

    logic        f_m0_ack, f_m0_err, f_m0_stall, f_m1_ack, f_m1_err, f_m1_stall;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_addr, f_data;
    logic        f_cyc, f_stb, f_we;
    logic [1:0]  f_grant;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A0 = 32'ha000_0010;
    localparam logic [31:0] A1 = 32'hb000_0020;

    wb_bus_arbiter #(.RR_MODE(1), .TIMEOUT(8), .OUT_W(4)) u_rr (
        .clk(clk), .reset(reset),
        .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
        .m0_wb_addr(m0_wb_addr), .m0_wb_wdata(m0_wb_wdata),
        .m0_wb_ack(m0_wb_ack), .m0_wb_err(m0_wb_err), .m0_wb_stall(m0_wb_stall),
        .m0_wb_rdata(m0_wb_rdata),
        .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
        .m1_wb_addr(m1_wb_addr), .m1_wb_wdata(m1_wb_wdata),
        .m1_wb_ack(m1_wb_ack), .m1_wb_err(m1_wb_err), .m1_wb_stall(m1_wb_stall),
        .m1_wb_rdata(m1_wb_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_data(i_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
        .o_grant(o_grant)
    );

    wb_bus_arbiter #(.RR_MODE(0), .TIMEOUT(8), .OUT_W(4)) u_fp (
        .clk(clk), .reset(reset),
        .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
        .m0_wb_addr(m0_wb_addr), .m0_wb_wdata(m0_wb_wdata),
        .m0_wb_ack(f_m0_ack), .m0_wb_err(f_m0_err), .m0_wb_stall(f_m0_stall),
        .m0_wb_rdata(f_m0_rdata),
        .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
        .m1_wb_addr(m1_wb_addr), .m1_wb_wdata(m1_wb_wdata),
        .m1_wb_ack(f_m1_ack), .m1_wb_err(f_m1_err), .m1_wb_stall(f_m1_stall),
        .m1_wb_rdata(f_m1_rdata),
        .o_wb_cyc(f_cyc), .o_wb_stb(f_stb), .o_wb_we(f_we),
        .o_wb_addr(f_addr), .o_wb_data(f_data), .i_wb_data(i_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
        .o_grant(f_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       c0, s0, c1, s1, sstall, sack;
        logic [1:0] g_rr, g_fp;
        logic       ocyc, ostb;
        logic [1:0] asel;
        logic       st0, st1, a0, a1;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] waddr[3];
    logic [31:0] seen[3];
    logic [31:0] exp_addr;
    int idx, stall_cnt, acc, acks, errcnt, errk;
    logic ack_pend, ocyc_err;

    initial begin
        //             c0 s0 c1 s1 sst sak  grr    gfp   cyc stb asel st0 st1 a0 a1
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b1,1'b1,2'd1, 1'b0,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b01,2'b01, 1'b1,1'b0,2'd1, 1'b0,1'b1,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,2'd1, 1'b0,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b10,2'b10, 1'b1,1'b0,2'd2, 1'b1,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b10, 1'b0,1'b0,2'd2, 1'b1,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,2'd1, 1'b0,1'b1,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 2'b10,2'b01, 1'b1,1'b1,2'd2, 1'b1,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01, 1'b0,1'b0,2'd2, 1'b1,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01, 1'b0,1'b0,2'd1, 1'b0,1'b1,1'b0,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,2'd0, 1'b1,1'b1,1'b0,1'b0};
        waddr[0] = 32'hb000_fff8;
        waddr[1] = 32'hb000_fffc;
        waddr[2] = 32'hb001_0000;

        reset = 1'b0;
        m0_wb_cyc = 0; m0_wb_stb = 0; m0_wb_we = 0; m0_wb_addr = A0; m0_wb_wdata = 32'h1111_0000;
        m1_wb_cyc = 0; m1_wb_stb = 0; m1_wb_we = 0; m1_wb_addr = A1; m1_wb_wdata = 32'h2222_0000;
        i_wb_data = 32'h0; i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0;
        repeat (2) step();
        chk("rst grant", {30'd0, o_grant}, 32'd0);
        chk("rst cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("rst addr", o_wb_addr, 32'd0);
        chk("rst stalls", {30'd0, m1_wb_stall, m0_wb_stall}, 32'd3);
        chk("rst acks", {28'd0, m1_wb_err, m0_wb_err, m1_wb_ack, m0_wb_ack}, 32'd0);
        reset = 1'b1;
        step();

        // Arbitration / forwarding vectors, one row per clock.
        for (int i = 0; i < 16; i++) begin
            step();
            m0_wb_cyc = tbl[i].c0; m0_wb_stb = tbl[i].s0;
            m1_wb_cyc = tbl[i].c1; m1_wb_stb = tbl[i].s1;
            i_wb_stall = tbl[i].sstall; i_wb_ack = tbl[i].sack;
            #3;
            exp_addr = (tbl[i].asel == 2'd1) ? A0 : (tbl[i].asel == 2'd2) ? A1 : 32'd0;
            chk($sformatf("row%0d grant_rr", i), {30'd0, o_grant}, {30'd0, tbl[i].g_rr});
            chk($sformatf("row%0d grant_fp", i), {30'd0, f_grant}, {30'd0, tbl[i].g_fp});
            chk($sformatf("row%0d cyc_stb", i), {30'd0, o_wb_cyc, o_wb_stb}, {30'd0, tbl[i].ocyc, tbl[i].ostb});
            chk($sformatf("row%0d addr", i), o_wb_addr, exp_addr);
            chk($sformatf("row%0d stalls", i), {30'd0, m1_wb_stall, m0_wb_stall}, {30'd0, tbl[i].st1, tbl[i].st0});
            chk($sformatf("row%0d acks", i), {30'd0, m1_wb_ack, m0_wb_ack}, {30'd0, tbl[i].a1, tbl[i].a0});
        end
        step();
        m0_wb_cyc = 0; m0_wb_stb = 0; m1_wb_cyc = 0; m1_wb_stb = 0; i_wb_ack = 0; i_wb_stall = 0;
        step();

        // Single read from m1.
        m1_wb_cyc = 1; m1_wb_stb = 1; m1_wb_addr = 32'hb000_0000;
        #3;
        chk("rd t0 stb", {31'd0, o_wb_stb}, 32'd0);
        chk("rd t0 m0 stall", {31'd0, m0_wb_stall}, 32'd1);
        step(); #3;
        chk("rd t1 stb", {31'd0, o_wb_stb}, 32'd1);
        chk("rd t1 grant", {30'd0, o_grant}, 32'd2);
        chk("rd t1 addr", o_wb_addr, 32'hb000_0000);
        chk("rd t1 m0 stall", {31'd0, m0_wb_stall}, 32'd1);
        step(); m1_wb_stb = 0; #3;
        chk("rd t2 ack", {31'd0, m1_wb_ack}, 32'd0);
        step(); i_wb_ack = 1; i_wb_data = 32'hdead_beef; #3;
        chk("rd t3 ack", {31'd0, m1_wb_ack}, 32'd1);
        chk("rd t3 rdata", m1_wb_rdata, 32'hdead_beef);
        chk("rd t3 m0 ack", {31'd0, m0_wb_ack}, 32'd0);
        chk("rd t3 m0 stall", {31'd0, m0_wb_stall}, 32'd1);
        step(); i_wb_ack = 0; m1_wb_cyc = 0;
        step();

        // Pipelined writes from m0 with the slave stalling the first two strobes.
        idx = 0; stall_cnt = 0; acc = 0; acks = 0; ack_pend = 0;
        m0_wb_cyc = 1; m0_wb_we = 1;
        for (int c = 0; c < 30; c++) begin
            m0_wb_stb = (idx < 3);
            m0_wb_addr = (idx < 3) ? waddr[idx] : 32'd0;
            m0_wb_wdata = 32'h5000_0000 + 32'(idx);
            i_wb_ack = ack_pend; ack_pend = 0;
            #1;
            if (o_wb_stb && stall_cnt < 2) begin
                i_wb_stall = 1; stall_cnt++;
            end else begin
                i_wb_stall = 0;
            end
            #2;
            if (m0_wb_ack) acks++;
            if (m0_wb_stb && !m0_wb_stall) begin
                if (acc < 3) seen[acc] = o_wb_addr;
                acc++; idx++; ack_pend = 1;
            end
            if (acks >= 3) break;
            step();
        end
        step(); m0_wb_stb = 0; i_wb_ack = 0; i_wb_stall = 0; #3;
        chk("wr accepted", 32'(acc), 32'd3);
        for (int k = 0; k < 3; k++) chk($sformatf("wr addr%0d", k), seen[k], waddr[k]);
        chk("wr acks", 32'(acks), 32'd3);
        chk("wr outstanding", {28'd0, u_rr.outstanding}, 32'd0);
        m0_wb_cyc = 0; m0_wb_we = 0;
        step(); step();

        // Ack timeout on m1 with m0 waiting.
        m1_wb_cyc = 1; m1_wb_stb = 1; m1_wb_addr = 32'hb000_0040;
        step(); #3;
        chk("to accept", {31'd0, o_wb_stb & ~m1_wb_stall}, 32'd1);
        chk("to grant", {30'd0, o_grant}, 32'd2);
        errcnt = 0; errk = 0; ocyc_err = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                m1_wb_stb = 0; m0_wb_cyc = 1;
            end
            #3;
            if (m1_wb_err) begin
                errcnt++; errk = k; ocyc_err = o_wb_cyc;
            end
            if (k == 10) chk("to idle grant", {30'd0, o_grant}, 32'd0);
            if (k == 11) chk("to m0 grant", {30'd0, o_grant}, 32'd1);
        end
        chk("to err count", 32'(errcnt), 32'd1);
        chk("to err cycle", 32'(errk), 32'd9);
        chk("to cyc at err", {31'd0, ocyc_err}, 32'd0);
        step(); m0_wb_cyc = 0; m1_wb_cyc = 0;
        step(); step();

        // Asynchronous reset in the middle of an m0 burst.
        m0_wb_cyc = 1; m0_wb_stb = 1; m0_wb_addr = 32'ha000_0100;
        step(); #3;
        chk("ar pre cyc", {31'd0, o_wb_cyc}, 32'd1);
        chk("ar pre grant", {30'd0, o_grant}, 32'd1);
        step(); #1;
        reset = 1'b0;
        #1;
        chk("ar cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("ar stb", {31'd0, o_wb_stb}, 32'd0);
        chk("ar grant", {30'd0, o_grant}, 32'd0);
        chk("ar stalls", {30'd0, m1_wb_stall, m0_wb_stall}, 32'd3);
        m0_wb_cyc = 0; m0_wb_stb = 0;
        step(); reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
